// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator and the downstream kernel.
// Tap indices follow the raster layout 0 1 2 / 3 . 4 / 5 6 7.
package sobel_pkg;

    localparam int PIX_W = 8;
    typedef logic [PIX_W-1:0] pix_t;

    localparam int NUM_TAPS = 8;
    localparam int WIN_TL   = 0;
    localparam int WIN_TC   = 1;
    localparam int WIN_TR   = 2;
    localparam int WIN_ML   = 3;
    localparam int WIN_MR   = 4;
    localparam int WIN_BL   = 5;
    localparam int WIN_BC   = 6;
    localparam int WIN_BR   = 7;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage: one write port plus one registered read port.
// The read port is addressed one column ahead so data is ready when that pixel arrives.
module sobel_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: contents are never observed before two full lines are written.
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr_i];
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel kernel (centre tap not emitted).
// Optional SOBEL_WIN_SOF_EN adds a 'sof' input that realigns the counters to (0,0).
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = sobel_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
`ifdef SOBEL_WIN_SOF_EN
    input  logic             sof,
`endif
    output logic             win_valid,
    output logic [PIX_W-1:0] win0,
    output logic [PIX_W-1:0] win1,
    output logic [PIX_W-1:0] win2,
    output logic [PIX_W-1:0] win3,
    output logic [PIX_W-1:0] win4,
    output logic [PIX_W-1:0] win5,
    output logic [PIX_W-1:0] win6,
    output logic [PIX_W-1:0] win7,
    output logic             win_last
);
    import sobel_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          restart;

`ifdef SOBEL_WIN_SOF_EN
    assign restart = pix_valid & sof;
`else
    assign restart = 1'b0;
`endif

    // Position of the pixel being accepted this cycle.
    assign col_cur = restart ? '0 : col_q;
    assign row_cur = restart ? '0 : row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end
    end

    logic [PIX_W-1:0] lb_a_rd, lb_b_rd;

    // lb_a holds row r-1, lb_b row r-2; lb_b is refilled from lb_a's old entry.
    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_a (
        .clk     (clk),
        .we_i    (pix_valid),
        .waddr_i (col_cur),
        .wdata_i (pix_in),
        .raddr_i (col_d),
        .rdata_o (lb_a_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_b (
        .clk     (clk),
        .we_i    (pix_valid),
        .waddr_i (col_cur),
        .wdata_i (lb_a_rd),
        .raddr_i (col_d),
        .rdata_o (lb_b_rd)
    );

    // Column c arrives live; sr_q[k][0] is column c-1 and sr_q[k][1] column c-2 of row k.
    logic [2:0][PIX_W-1:0]      col_new;
    logic [2:0][1:0][PIX_W-1:0] sr_q, sr_d;
    logic [NUM_TAPS-1:0][PIX_W-1:0] taps_q, taps_d;
    logic win_valid_q, win_valid_d, win_last_q, win_last_d;
    logic hit;

    assign col_new = {pix_in, lb_a_rd, lb_b_rd};
    assign hit     = pix_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

    always_comb begin
        sr_d        = sr_q;
        taps_d      = taps_q;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        if (pix_valid) begin
            for (int k = 0; k < 3; k++) sr_d[k] = {sr_q[k][0], col_new[k]};
        end
        if (hit) begin
            taps_d[WIN_TL] = sr_q[0][1];
            taps_d[WIN_TC] = sr_q[0][0];
            taps_d[WIN_TR] = col_new[0];
            taps_d[WIN_ML] = sr_q[1][1];
            taps_d[WIN_MR] = col_new[1];
            taps_d[WIN_BL] = sr_q[2][1];
            taps_d[WIN_BC] = sr_q[2][0];
            taps_d[WIN_BR] = col_new[2];
            win_valid_d    = 1'b1;
            win_last_d     = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            sr_q        <= '0;
            taps_q      <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sr_q        <= sr_d;
            taps_q      <= taps_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win0 = taps_q[WIN_TL];
    assign win1 = taps_q[WIN_TC];
    assign win2 = taps_q[WIN_TR];
    assign win3 = taps_q[WIN_ML];
    assign win4 = taps_q[WIN_MR];
    assign win5 = taps_q[WIN_BL];
    assign win6 = taps_q[WIN_BC];
    assign win7 = taps_q[WIN_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image against a frame-array model.
// The sof scenario runs only when SOBEL_WIN_SOF_EN is defined.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       sof;
    logic       win_valid, win_last;
    logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
`ifdef SOBEL_WIN_SOF_EN
        .sof       (sof),
`endif
        .win_valid (win_valid),
        .win0      (win0),
        .win1      (win1),
        .win2      (win2),
        .win3      (win3),
        .win4      (win4),
        .win5      (win5),
        .win6      (win6),
        .win7      (win7),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the current frame as a 2-D array plus raster position.
    int         img [H][W];
    int         mr, mc;
    int         DR [8] = '{-2, -2, -2, -1, -1, 0, 0, 0};
    int         DC [8] = '{-2, -1, 0, -2, 0, -2, -1, 0};
    logic       ev, el, ov, ol;
    logic [63:0] et, ot;

    function automatic logic [7:0] pix_val(input int kind, input int r, input int c);
        if (kind == 0) return 8'(16 * r + c);
        if (kind == 1) return 8'(255 - (16 * r + c));
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic model_reset();
        mr = 0;
        mc = 0;
        et = '0;
    endtask

    // One clock: drive, let the DUT sample, observe #1 later, advance the model.
    task automatic step(input logic v, input logic [7:0] p, input logic s);
        pix_valid = v;
        pix_in    = p;
        sof       = s;
        @(posedge clk);
        #1;
        ev = 1'b0;
        el = 1'b0;
        if (v) begin
`ifdef SOBEL_WIN_SOF_EN
            if (s) begin mr = 0; mc = 0; end
`endif
            img[mr][mc] = int'(p);
            if (mr >= 2 && mc >= 2) begin
                ev = 1'b1;
                el = (mr == H - 1) && (mc == W - 1);
                for (int k = 0; k < 8; k++) et[8*k +: 8] = 8'(img[mr + DR[k]][mc + DC[k]]);
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        ov = win_valid;
        ol = win_last;
        ot = {win7, win6, win5, win4, win3, win2, win1, win0};
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        sof = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({win_valid, win_last, win7, win6, win5, win4, win3, win2, win1, win0} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b l=%0b taps=%h want all zero", win_valid, win_last,
                     {win7, win6, win5, win4, win3, win2, win1, win0});
        end
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (ov !== 1'b0 || ot !== 64'h0) begin
            n_err++;
            $display("FAIL reset_idle: got v=%0b taps=%h want v=0 taps=0", ov, ot);
        end
    endtask

    task automatic test_single_frame();
        int nw = 0;
        int nl = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, pix_val(0, r, c), 1'b0);
                n_cmp++;
                if (ov !== ev || ol !== el || ot !== et) begin
                    n_err++;
                    $display("FAIL frame_px(%0d,%0d): got v=%0b l=%0b taps=%h want v=%0b l=%0b taps=%h",
                             r, c, ov, ol, ot, ev, el, et);
                end
                if (ov === 1'b1) begin
                    nw++;
                    if (nw == 1) begin
                        n_cmp++;
                        if (ot !== 64'h2221201210020100 || r != 2 || c != 2) begin
                            n_err++;
                            $display("FAIL first_window: got taps=%h at (%0d,%0d) want 2221201210020100 at (2,2)",
                                     ot, r, c);
                        end
                    end
                    if (ol === 1'b1) begin
                        nl++;
                        n_cmp++;
                        if (ot !== 64'h3332312321131211) begin
                            n_err++;
                            $display("FAIL last_window: got taps=%h want 3332312321131211", ot);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (nw != 4 || nl != 1) begin
            n_err++;
            $display("FAIL window_count: got %0d windows %0d last want 4 windows 1 last", nw, nl);
        end
    endtask

    task automatic test_gaps();
        int nw = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
                    n_cmp++;
                    if (ov !== 1'b0 || ol !== 1'b0 || ot !== et) begin
                        n_err++;
                        $display("FAIL gap_hold: got v=%0b l=%0b taps=%h want v=0 l=0 taps=%h", ov, ol, ot, et);
                    end
                end
                step(1'b1, pix_val(0, r, c), 1'b0);
                n_cmp++;
                if (ov !== ev || ol !== el || ot !== et) begin
                    n_err++;
                    $display("FAIL gap_px(%0d,%0d): got v=%0b l=%0b taps=%h want v=%0b l=%0b taps=%h",
                             r, c, ov, ol, ot, ev, el, et);
                end
                if (ov === 1'b1) nw++;
            end
        end
        n_cmp++;
        if (nw != 4) begin
            n_err++;
            $display("FAIL gap_count: got %0d windows want 4", nw);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            int nw = 0;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    step(1'b1, pix_val(f, r, c), 1'b0);
                    n_cmp++;
                    if (ov !== ev || ol !== el || ot !== et) begin
                        n_err++;
                        $display("FAIL b2b_f%0d(%0d,%0d): got v=%0b l=%0b taps=%h want v=%0b l=%0b taps=%h",
                                 f, r, c, ov, ol, ot, ev, el, et);
                    end
                    if (ov === 1'b1) nw++;
                    if (f == 1 && r == 2 && c == 2) begin
                        n_cmp++;
                        if (ot !== 64'hDDDEDFEDEFFDFEFF) begin
                            n_err++;
                            $display("FAIL b2b_inverted: got taps=%h want dddedfedeffdfeff", ot);
                        end
                    end
                end
            end
            n_cmp++;
            if (nw != 4) begin
                n_err++;
                $display("FAIL b2b_count_f%0d: got %0d windows want 4", f, nw);
            end
        end
    endtask

    task automatic test_mid_reset();
        int nw = 0;
        for (int i = 0; i < 9; i++) step(1'b1, pix_val(0, i / W, i % W), 1'b0);
        pix_valid = 1'b1;
        pix_in    = 8'h21;
        rst_n     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({win_valid, win_last, win7, win6, win5, win4, win3, win2, win1, win0} !== '0) begin
                n_err++;
                $display("FAIL midreset_outputs%0d: got v=%0b l=%0b taps=%h want all zero", i, win_valid, win_last,
                         {win7, win6, win5, win4, win3, win2, win1, win0});
            end
            @(posedge clk);
        end
        #1;
        pix_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, pix_val(0, r, c), 1'b0);
                n_cmp++;
                if (ov !== ev || ol !== el || ot !== et) begin
                    n_err++;
                    $display("FAIL midreset_px(%0d,%0d): got v=%0b l=%0b taps=%h want v=%0b l=%0b taps=%h",
                             r, c, ov, ol, ot, ev, el, et);
                end
                if (ov === 1'b1) begin
                    nw++;
                    if (nw == 1) begin
                        n_cmp++;
                        if (ot !== 64'h2221201210020100 || r != 2 || c != 2) begin
                            n_err++;
                            $display("FAIL midreset_first: got taps=%h at (%0d,%0d) want 2221201210020100 at (2,2)",
                                     ot, r, c);
                        end
                    end
                end
            end
        end
    endtask

`ifdef SOBEL_WIN_SOF_EN
    task automatic test_sof();
        int first_k = -1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int k = 0; k < W * H; k++) begin
            step(1'b1, 8'($urandom_range(0, 255)), (k == 0) ? 1'b1 : 1'b0);
            n_cmp++;
            if (ov !== ev || ol !== el || ot !== et) begin
                n_err++;
                $display("FAIL sof_px%0d: got v=%0b l=%0b taps=%h want v=%0b l=%0b taps=%h",
                         k, ov, ol, ot, ev, el, et);
            end
            if (ov === 1'b1 && first_k < 0) first_k = k;
        end
        n_cmp++;
        if (first_k != 10) begin
            n_err++;
            $display("FAIL sof_first_window: got offset %0d want 10", first_k);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
`ifdef SOBEL_WIN_SOF_EN
        test_sof();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
